// File: rtl/hwregs_pkg.sv
// Shared definitions for the hwregs peripheral: register offsets, UART
// shifter states and UART_STAT bit positions.
package hwregs_pkg;

  localparam logic [7:0] HWREGS_LED       = 8'h00;
  localparam logic [7:0] HWREGS_SWITCH    = 8'h04;
  localparam logic [7:0] HWREGS_UART_TX   = 8'h08;
  localparam logic [7:0] HWREGS_UART_STAT = 8'h0C;
  localparam logic [7:0] HWREGS_TIMER     = 8'h10;

  localparam int STAT_BUSY_BIT     = 0;
  localparam int STAT_OVERFLOW_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/hwregs_if.sv
// CPU data-port request/response bundle between the address decoder and hwregs.
interface hwregs_if;

  logic        cpu_hwregs_req;
  logic [15:0] cpu_hwregs_addr;
  logic        cpu_hwregs_write;
  logic [31:0] cpu_hwregs_wdata;
  logic [3:0]  cpu_hwregs_wmask;
  logic        cpu_hwregs_ack;
  logic [31:0] cpu_hwregs_rdata;

  modport master (
    output cpu_hwregs_req, cpu_hwregs_addr, cpu_hwregs_write,
           cpu_hwregs_wdata, cpu_hwregs_wmask,
    input  cpu_hwregs_ack, cpu_hwregs_rdata
  );

  modport slave (
    input  cpu_hwregs_req, cpu_hwregs_addr, cpu_hwregs_write,
           cpu_hwregs_wdata, cpu_hwregs_wmask,
    output cpu_hwregs_ack, cpu_hwregs_rdata
  );

endinterface

// File: rtl/hwregs_uart_tx.sv
// FIFO-buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop
// shifter with a registered, idle-high serial output.
module hwregs_uart_tx
  import hwregs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [7:0]                  push_data,
  output logic                        accept,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy,
  output logic                        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;

  uart_state_t   state, state_next;
  logic [BW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          tx_q, tx_next;
  logic          pop, empty, full, bit_done;

  assign empty    = (fifo_count == '0);
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign bit_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign accept   = push && (!full || pop);
  assign count    = fifo_count;
  assign busy     = !empty || (state != IDLE);
  assign uart_tx  = tx_q;

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_next  = '0;
          shift_next = shift >> 1;
          if (bit_idx == 3'd7) state_next = STOP;
          else                 bit_next   = bit_idx + 3'd1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_next = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      tx_q     <= tx_next;
    end
  end

endmodule

// File: rtl/hwregs.sv
// Memory-mapped register block: LEDs, synchronised switches, cycle timer and
// UART transmitter, answering with a registered ack/rdata pair.
module hwregs
  import hwregs_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  hwregs_if.slave    cpu,
  output logic [9:0] leds,
  input  logic [9:0] switches,
  output logic       uart_tx
);

  logic [9:0]  sw_meta, sw_sync;
  logic [31:0] timer;
  logic        overflow;
  logic [31:0] read_val;
  logic [7:0]  offset;
  logic        in_page, wr, rd;
  logic        push, accept, busy;
  logic [$clog2(FIFO_DEPTH):0] uart_count;
  logic        unused_addr_bits;

  // Only the top 8 offset bits are decoded against zero; everything above 0xFF is unmapped.
  assign offset           = {cpu.cpu_hwregs_addr[7:2], 2'b00};
  assign in_page          = (cpu.cpu_hwregs_addr[15:8] == 8'h00);
  assign wr               = cpu.cpu_hwregs_req && cpu.cpu_hwregs_write && in_page;
  assign rd               = cpu.cpu_hwregs_req && !cpu.cpu_hwregs_write;
  assign push             = wr && (offset == HWREGS_UART_TX) && cpu.cpu_hwregs_wmask[0];
  assign unused_addr_bits = ^cpu.cpu_hwregs_addr[1:0];

  hwregs_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_uart_tx (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(cpu.cpu_hwregs_wdata[7:0]),
    .accept   (accept),
    .count    (uart_count),
    .busy     (busy),
    .uart_tx  (uart_tx)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      leds     <= '0;
      timer    <= '0;
      overflow <= 1'b0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;

      if (wr && offset == HWREGS_LED) begin
        if (cpu.cpu_hwregs_wmask[0]) leds[7:0] <= cpu.cpu_hwregs_wdata[7:0];
        if (cpu.cpu_hwregs_wmask[1]) leds[9:8] <= cpu.cpu_hwregs_wdata[9:8];
      end

      if (wr && offset == HWREGS_TIMER && cpu.cpu_hwregs_wmask == 4'hF)
        timer <= cpu.cpu_hwregs_wdata;
      else
        timer <= timer + 32'd1;

      if (push && !accept)
        overflow <= 1'b1;
      else if (wr && offset == HWREGS_UART_STAT && cpu.cpu_hwregs_wmask[0] &&
               cpu.cpu_hwregs_wdata[STAT_OVERFLOW_BIT])
        overflow <= 1'b0;
    end
  end

  always_comb begin
    read_val = '0;
    if (in_page) begin
      case (offset)
        HWREGS_LED:     read_val[9:0] = leds;
        HWREGS_SWITCH:  read_val[9:0] = sw_sync;
        HWREGS_UART_TX: read_val      = 32'(FIFO_DEPTH) - 32'(uart_count);
        HWREGS_UART_STAT: begin
          read_val[STAT_BUSY_BIT]     = busy;
          read_val[STAT_OVERFLOW_BIT] = overflow;
        end
        HWREGS_TIMER:   read_val      = timer;
        default:        read_val      = '0;
      endcase
    end
  end

  // rdata is forced to zero outside read acks so responders can be OR-merged.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cpu.cpu_hwregs_ack   <= 1'b0;
      cpu.cpu_hwregs_rdata <= '0;
    end else begin
      cpu.cpu_hwregs_ack   <= cpu.cpu_hwregs_req;
      cpu.cpu_hwregs_rdata <= rd ? read_val : '0;
    end
  end

endmodule

// File: tb/tb_hwregs.sv
// Self-checking bench for hwregs: per-feature test tasks with a read-data
// queue and a serial-byte queue as scoreboards.
module tb_hwregs;
  import hwregs_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp;
    logic        tmr;
  } acc_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] leds;
  logic [9:0] switches;
  logic       uart_tx;

  hwregs_if bus();

  hwregs #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .cpu     (bus),
    .leds    (leds),
    .switches(switches),
    .uart_tx (uart_tx)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  byte_q[$];
  logic [31:0] timer_base_val;
  int          timer_base_cyc;

  // Timer value during cycle c, counted from the last load or reset.
  function automatic logic [31:0] timer_at(int c);
    return timer_base_val + 32'(c - timer_base_cyc);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    bus.cpu_hwregs_req   = 1'b1;
    bus.cpu_hwregs_write = w;
    bus.cpu_hwregs_addr  = a;
    bus.cpu_hwregs_wdata = d;
    bus.cpu_hwregs_wmask = m;
  endtask

  task automatic idle_bus();
    bus.cpu_hwregs_req   = 1'b0;
    bus.cpu_hwregs_write = 1'b0;
    bus.cpu_hwregs_addr  = '0;
    bus.cpu_hwregs_wdata = '0;
    bus.cpu_hwregs_wmask = '0;
  endtask

  task automatic test_reset();
    acc_t t [4];
    logic [31:0] exp;
    idle_bus();
    switches = '0;
    reset_n  = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.cpu_hwregs_ack !== 1'b0) $display("[TB] FAIL reset_ack: got %b want 0", bus.cpu_hwregs_ack); else n_pass++;
    n_checks++; if (bus.cpu_hwregs_rdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h want 0", bus.cpu_hwregs_rdata); else n_pass++;
    n_checks++; if (leds !== 10'h0) $display("[TB] FAIL reset_leds: got %h want 0", leds); else n_pass++;
    n_checks++; if (uart_tx !== 1'b1) $display("[TB] FAIL reset_uart_tx: got %b want 1", uart_tx); else n_pass++;
    reset_n        = 1'b1;
    timer_base_val = 32'h0;
    timer_base_cyc = cyc;
    t[0] = '{1'b0, 16'h0000, 32'h0, 4'h0, 32'h0, 1'b0};
    t[1] = '{1'b0, 16'h0008, 32'h0, 4'h0, 32'(DEPTH), 1'b0};
    t[2] = '{1'b0, 16'h000C, 32'h0, 4'h0, 32'h0, 1'b0};
    t[3] = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'h0, 1'b1};
    foreach (t[i]) begin
      drive(t[i].w, t[i].a, t[i].d, t[i].m);
      rd_q.push_back(t[i].tmr ? timer_at(cyc) : t[i].exp);
      tick();
      idle_bus();
      exp = rd_q.pop_front();
      n_checks++; if (bus.cpu_hwregs_ack !== 1'b1) $display("[TB] FAIL reset_rd_ack%0d: got %b want 1", i, bus.cpu_hwregs_ack); else n_pass++;
      n_checks++; if (bus.cpu_hwregs_rdata !== exp) $display("[TB] FAIL reset_rd%0d: got %h want %h", i, bus.cpu_hwregs_rdata, exp); else n_pass++;
    end
    tick();
    n_checks++; if (bus.cpu_hwregs_ack !== 1'b0) $display("[TB] FAIL idle_ack: got %b want 0", bus.cpu_hwregs_ack); else n_pass++;
    n_checks++; if (bus.cpu_hwregs_rdata !== 32'h0) $display("[TB] FAIL idle_rdata: got %h want 0", bus.cpu_hwregs_rdata); else n_pass++;
  endtask

  task automatic test_leds();
    acc_t t [3];
    logic [31:0] exp;
    drive(1'b1, 16'h0000, 32'h3FF, 4'b0001);
    tick();
    idle_bus();
    n_checks++; if (leds !== 10'h0FF) $display("[TB] FAIL led_lane0: got %h want 0ff", leds); else n_pass++;
    drive(1'b1, 16'h0000, 32'h3FF, 4'b0011);
    tick();
    idle_bus();
    n_checks++; if (leds !== 10'h3FF) $display("[TB] FAIL led_lane01: got %h want 3ff", leds); else n_pass++;
    t[0] = '{1'b0, 16'h0000, 32'h0, 4'h0, 32'h3FF, 1'b0};
    t[1] = '{1'b0, 16'h0003, 32'h0, 4'h0, 32'h3FF, 1'b0};
    t[2] = '{1'b0, 16'h0100, 32'h0, 4'h0, 32'h0, 1'b0};
    foreach (t[i]) begin
      drive(t[i].w, t[i].a, t[i].d, t[i].m);
      rd_q.push_back(t[i].exp);
      tick();
      idle_bus();
      exp = rd_q.pop_front();
      n_checks++; if (bus.cpu_hwregs_ack !== 1'b1) $display("[TB] FAIL led_ack%0d: got %b want 1", i, bus.cpu_hwregs_ack); else n_pass++;
      n_checks++; if (bus.cpu_hwregs_rdata !== exp) $display("[TB] FAIL led_rd%0d: got %h want %h", i, bus.cpu_hwregs_rdata, exp); else n_pass++;
    end
  endtask

  task automatic test_switches();
    logic [31:0] exp_tab [3];
    logic [31:0] exp;
    exp_tab[0] = 32'h0;
    exp_tab[1] = 32'h0;
    exp_tab[2] = 32'h2A5;
    switches = 10'h2A5;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0004, 32'h0, 4'h0);
      rd_q.push_back(exp_tab[i]);
      tick();
      idle_bus();
      exp = rd_q.pop_front();
      n_checks++; if (bus.cpu_hwregs_rdata !== exp) $display("[TB] FAIL switch_rd%0d: got %h want %h", i, bus.cpu_hwregs_rdata, exp); else n_pass++;
    end
  endtask

  task automatic test_uart_frame();
    logic [39:0] samples;
    logic [9:0]  frame;
    logic [7:0]  exp_byte;
    logic        found;
    drive(1'b1, 16'h0008, 32'hA5, 4'b0001);
    byte_q.push_back(8'hA5);
    tick();
    idle_bus();
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (uart_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_checks++; if (!found) $display("[TB] FAIL uart_start_seen: got none want start bit within 10 cycles"); else n_pass++;
    samples = '0;
    for (int j = 0; j < 40; j++) begin
      samples[j] = uart_tx;
      if (j == 38) begin
        n_checks++; if (bus.cpu_hwregs_rdata !== 32'h1) $display("[TB] FAIL uart_busy_stop: got %h want 1", bus.cpu_hwregs_rdata); else n_pass++;
      end
      if (j == 37) drive(1'b0, 16'h000C, 32'h0, 4'h0);
      tick();
      idle_bus();
    end
    exp_byte = byte_q.pop_front();
    frame    = {1'b1, exp_byte, 1'b0};
    for (int b = 0; b < 10; b++) begin
      n_checks++;
      if (samples[b*4 +: 4] !== {4{frame[b]}})
        $display("[TB] FAIL uart_bit%0d: got %b want %b", b, samples[b*4 +: 4], {4{frame[b]}});
      else n_pass++;
    end
    drive(1'b0, 16'h000C, 32'h0, 4'h0);
    tick();
    idle_bus();
    n_checks++; if (bus.cpu_hwregs_rdata !== 32'h0) $display("[TB] FAIL uart_busy_clear: got %h want 0", bus.cpu_hwregs_rdata); else n_pass++;
  endtask

  task automatic test_overflow();
    acc_t t [4];
    logic [31:0] exp;
    logic [7:0]  b_val;
    logic [9:0]  got_frame;
    logic [7:0]  exp_byte;
    logic        found;
    int          acks;
    acks = 0;
    // First byte is all ones so its frame only goes low during the start bit.
    for (int i = 0; i < 18; i++) begin
      b_val = (i == 0) ? 8'hFF : 8'(8'h10 + i);
      drive(1'b1, 16'h0008, {24'h0, b_val}, 4'b0001);
      if (i < 17) byte_q.push_back(b_val);
      tick();
      idle_bus();
      if (bus.cpu_hwregs_ack === 1'b1) acks++;
    end
    n_checks++; if (acks != 18) $display("[TB] FAIL push_acks: got %0d want 18", acks); else n_pass++;
    t[0] = '{1'b0, 16'h0008, 32'h0, 4'h0, 32'h0, 1'b0};
    t[1] = '{1'b0, 16'h000C, 32'h0, 4'h0, 32'h3, 1'b0};
    t[2] = '{1'b1, 16'h000C, 32'h2, 4'h1, 32'h0, 1'b0};
    t[3] = '{1'b0, 16'h000C, 32'h0, 4'h0, 32'h1, 1'b0};
    foreach (t[i]) begin
      drive(t[i].w, t[i].a, t[i].d, t[i].m);
      rd_q.push_back(t[i].exp);
      tick();
      idle_bus();
      exp = rd_q.pop_front();
      n_checks++; if (bus.cpu_hwregs_ack !== 1'b1) $display("[TB] FAIL ovf_ack%0d: got %b want 1", i, bus.cpu_hwregs_ack); else n_pass++;
      if (!t[i].w) begin
        n_checks++; if (bus.cpu_hwregs_rdata !== exp) $display("[TB] FAIL ovf_rd%0d: got %h want %h", i, bus.cpu_hwregs_rdata, exp); else n_pass++;
      end
    end
    void'(byte_q.pop_front());
    for (int f = 0; f < 16; f++) begin
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (uart_tx === 1'b0) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      n_checks++;
      if (!found) begin
        $display("[TB] FAIL ovf_start%0d: got none want start bit within 100 cycles", f);
        break;
      end
      n_pass++;
      repeat (2) tick();
      got_frame[0] = uart_tx;
      for (int b = 1; b < 9; b++) begin
        repeat (4) tick();
        got_frame[b] = uart_tx;
      end
      repeat (4) tick();
      got_frame[9] = uart_tx;
      exp_byte = (byte_q.size() > 0) ? byte_q.pop_front() : 8'h00;
      n_checks++;
      if (got_frame !== {1'b1, exp_byte, 1'b0})
        $display("[TB] FAIL ovf_frame%0d: got %b want %b", f, got_frame, {1'b1, exp_byte, 1'b0});
      else n_pass++;
    end
    repeat (2) tick();
    drive(1'b0, 16'h000C, 32'h0, 4'h0);
    tick();
    drive(1'b0, 16'h0008, 32'h0, 4'h0);
    n_checks++; if (bus.cpu_hwregs_rdata !== 32'h0) $display("[TB] FAIL ovf_drained_stat: got %h want 0", bus.cpu_hwregs_rdata); else n_pass++;
    tick();
    idle_bus();
    n_checks++; if (bus.cpu_hwregs_rdata !== 32'(DEPTH)) $display("[TB] FAIL ovf_drained_free: got %h want %h", bus.cpu_hwregs_rdata, 32'(DEPTH)); else n_pass++;
  endtask

  task automatic test_timer();
    acc_t t [4];
    logic [31:0] exp;
    drive(1'b1, 16'h0010, 32'hFFFF_FFFE, 4'hF);
    tick();
    idle_bus();
    timer_base_val = 32'hFFFF_FFFE;
    timer_base_cyc = cyc;
    tick();
    t[0] = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0};
    t[1] = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'h0, 1'b0};
    t[2] = '{1'b1, 16'h0010, 32'h1234_5678, 4'h1, 32'h0, 1'b0};
    t[3] = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'h0, 1'b1};
    foreach (t[i]) begin
      drive(t[i].w, t[i].a, t[i].d, t[i].m);
      rd_q.push_back(t[i].tmr ? timer_at(cyc) : t[i].exp);
      tick();
      idle_bus();
      exp = rd_q.pop_front();
      if (!t[i].w) begin
        n_checks++; if (bus.cpu_hwregs_rdata !== exp) $display("[TB] FAIL timer_rd%0d: got %h want %h", i, bus.cpu_hwregs_rdata, exp); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midframe();
    acc_t t [9];
    logic [31:0] exp;
    logic        found;
    int          lows;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0008, 32'h0, 4'b0001);
      byte_q.push_back(8'h00);
      tick();
      idle_bus();
    end
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (uart_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    repeat (6) tick();
    n_checks++; if (!found || uart_tx !== 1'b0) $display("[TB] FAIL midframe_low: got %b want 0", uart_tx); else n_pass++;
    reset_n = 1'b0;
    tick();
    n_checks++; if (uart_tx !== 1'b1) $display("[TB] FAIL midframe_abort: got %b want 1", uart_tx); else n_pass++;
    reset_n        = 1'b1;
    timer_base_val = 32'h0;
    timer_base_cyc = cyc;
    byte_q.delete();
    t[0] = '{1'b0, 16'h000C, 32'h0, 4'h0, 32'h0, 1'b0};
    t[1] = '{1'b0, 16'h0008, 32'h0, 4'h0, 32'(DEPTH), 1'b0};
    t[2] = '{1'b0, 16'h0020, 32'h0, 4'h0, 32'h0, 1'b0};
    t[3] = '{1'b0, 16'h0010, 32'h0, 4'h0, 32'h0, 1'b1};
    t[4] = '{1'b1, 16'h0000, 32'h155, 4'h3, 32'h0, 1'b0};
    t[5] = '{1'b1, 16'h0100, 32'h2AA, 4'hF, 32'h0, 1'b0};
    t[6] = '{1'b1, 16'h0014, 32'h2AA, 4'hF, 32'h0, 1'b0};
    t[7] = '{1'b0, 16'h0000, 32'h0, 4'h0, 32'h155, 1'b0};
    t[8] = '{1'b0, 16'hFFFC, 32'h0, 4'h0, 32'h0, 1'b0};
    foreach (t[i]) begin
      drive(t[i].w, t[i].a, t[i].d, t[i].m);
      rd_q.push_back(t[i].tmr ? timer_at(cyc) : t[i].exp);
      tick();
      idle_bus();
      exp = rd_q.pop_front();
      n_checks++; if (bus.cpu_hwregs_ack !== 1'b1) $display("[TB] FAIL post_rst_ack%0d: got %b want 1", i, bus.cpu_hwregs_ack); else n_pass++;
      if (!t[i].w) begin
        n_checks++; if (bus.cpu_hwregs_rdata !== exp) $display("[TB] FAIL post_rst_rd%0d: got %h want %h", i, bus.cpu_hwregs_rdata, exp); else n_pass++;
      end
    end
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      if (uart_tx !== 1'b1) lows++;
      tick();
    end
    n_checks++; if (lows != 0) $display("[TB] FAIL flushed_line_idle: got %0d low cycles want 0", lows); else n_pass++;
  endtask

  initial begin
    idle_bus();
    switches = '0;
    test_reset();
    test_leds();
    test_switches();
    test_uart_frame();
    test_overflow();
    test_timer();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/hwregs.md
# hwregs

Memory-mapped hardware register block at 0xE000_0000–0xE000_FFFF: the CPU data-port peripheral selected by `cpu_hwregs_req` from the data address decoder. Holds LED outputs, synchronised switch inputs, a free-running cycle timer, and a FIFO-buffered 8N1 UART transmitter. Returns a single-cycle registered ack/rdata pair whose rdata is zero whenever ack is low, so it can be OR-merged with the other data-port responders.

## Interface
- `CLKS_PER_BIT`, 868, UART bit period in clock cycles (≥2).
- `FIFO_DEPTH`, 16, UART TX FIFO entries (power of two, 2–256).
- `clock`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cpu_hwregs_req`  in  1  one-cycle access strobe from the address decoder.
- `cpu_hwregs_addr`  in  16  byte offset, cpud_addr[15:0]; bits [1:0] ignored.
- `cpu_hwregs_write`  in  1  1 = write, 0 = read; valid with req.
- `cpu_hwregs_wdata`  in  32  write data.
- `cpu_hwregs_wmask`  in  4  byte-lane enables for writes.
- `cpu_hwregs_ack`  out  1  access complete; exactly one cycle after req.
- `cpu_hwregs_rdata`  out  32  read data; 0 unless ack is high.
- `leds`  out  10  LED drive.
- `switches`  in  10  asynchronous switch inputs.
- `uart_tx`  out  1  serial output, idle high.

## Operation
- Register map (offset[7:0]; offsets 0x14–0xFFFC unmapped):
  - 0x00 LED RW: bits[9:0]; lane 0 writes [7:0], lane 1 writes [9:8].
  - 0x04 SWITCH RO: two-flop-synchronised `switches` in [9:0].
  - 0x08 UART_TX: write with wmask[0] pushes wdata[7:0]; read returns free entries (FIFO_DEPTH − count).
  - 0x0C UART_STAT: read bit0 = busy (FIFO non-empty or shifter active), bit1 = overflow (sticky); write with wmask[0] and wdata[1]=1 clears overflow.
  - 0x10 TIMER: read returns 32-bit cycle counter; write with wmask=4'hF loads wdata, any other mask ignored.
- Unmapped offsets: acked, rdata 0, writes ignored.
- Unused read bits are 0.
- Timer increments every cycle, wraps 0xFFFF_FFFF→0. A cycle in which it is loaded takes the written value (no increment that cycle).
- UART FIFO push when full: byte dropped, overflow set. If the shifter pops in the same cycle, the push is accepted.
- Shifter states IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE, each CLKS_PER_BIT cycles.
  - From IDLE, a non-empty FIFO pops and enters START on the next cycle.
  - At the end of STOP with FIFO non-empty, goes directly to START (no idle bit).
- Reset values: leds 0, uart_tx 1, ack 0, rdata 0, timer 0, FIFO empty, overflow 0, shifter IDLE, sync flops 0.
- Reset mid-frame aborts the frame: uart_tx returns to 1 on the cycle after reset is sampled low, and the FIFO is flushed.

## Timing
- Access in cycle N (req=1) → ack=1 and rdata valid in N+1. Ack is a register and has no combinational path from req.
- Writes take effect at the clock edge ending cycle N. A read of the same register in N+1 sees the new value.
- Back-to-back reqs are allowed. Each gets its own ack.
- Read data is sampled in cycle N: TIMER read in N returns the counter value present during N.
- SWITCH latency: 2 cycles of synchronisation plus the access cycle.
- Worst case, a pushed byte's start bit appears 2 cycles after the push edge when IDLE.

## Structure
- `hwregs_pkg`:
  - Register offset localparams (HWREGS_LED=0x00 … HWREGS_TIMER=0x10).
  - `uart_state_t` enum {IDLE, START, DATA, STOP}.
  - UART_STAT bit positions.
- Sub-module `uart_tx`:
  - FIFO, shifter FSM, bit/baud counters.
  - Ports: clock, reset_n, push, push_data[7:0], accept, count, busy, uart_tx.
  - Top level holds the register decode, LED/timer/sync flops, overflow flag and the ack/rdata register.

## Test plan
- Reset, then read 0x00, 0x08, 0x0C, 0x10 → rdata 0, 16 (FIFO_DEPTH), 0, then the cycle count since reset release; ack exactly one cycle after each req; rdata 0 on all non-ack cycles.
- Write 0x3FF to 0x00 with wmask 4'b0001 → leds = 0x0FF; then wmask 4'b0011 → leds 0x3FF; read back 0x3FF.
- CLKS_PER_BIT=4: push 0xA5 → uart_tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4; busy clears after stop.
- Push 18 bytes back-to-back while the first is shifting → 17 accepted, 1 dropped, overflow=1; write 0x2 to 0x0C → overflow 0.
- Write 0xFFFF_FFFE to TIMER with wmask F → reads 2 and 3 cycles later return 0xFFFF_FFFF… wrap to 0 observed; wmask 4'h1 write leaves the counter untouched.
- Assert reset_n=0 mid DATA bit → uart_tx=1 next cycle, busy=0, free=16 after release; read of unmapped 0x20 → ack, rdata 0.
